fht_control_param: RTL and testbench

Parametrised sequencer for the radix-2 in-place FHT over 4 RAM banks. Generalises the fixed 1024-point controller to any N = 2^N_LOG2. It generates the following for every stage:
- read and mirror (bias) read addresses
- write and write-bias addresses, delayed by the butterfly pipeline latency
- coefficient addresses
- ping-pong bank write enables
- stage, sector and half-sector flags for the bank mixers

It sits between the top-level start/ready handshake and the bank mixers, butterfly and coefficient ROM.

---
 rtl/fht_control_param.sv | 203 ++++++++++++++++++++
 tb/tb_fht_control_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_control_param.sv
// ---------------------------------------------------------------------------
// fht_control_param
// Address and strobe sequencer for a radix-2 in-place FHT of length
// 2^N_LOG2 spread over 4 RAM banks of depth D = 2^A_BIT.
//
// Each stage lasts L = 2*D + PIPE_LAT clocks:
//   - The read window is cnt < 2*D. Each read address is held for two
//     clocks because the butterfly takes two tacts per pair.
//   - The write window is cnt >= PIPE_LAT. It replays the read sequence
//     PIPE_LAT clocks later.
// The bank-set strobes ping-pong between stages.
//
// Optional build macro: FHT_STALL_EN
//   This adds input iSTALL, which freezes the sequencer while it is busy
//   and masks the write strobes.
//
// Ports:
//   iCLK, iRESET        clock, asynchronous active-low reset
//   iSTALL              (FHT_STALL_EN only) freeze request
//   iSTART              start request, sampled while oRDY=1
//   oRDY, oDONE         idle flag, one-cycle end-of-transform pulse
//   oSTAGE              current stage index
//   oST_ZERO, oST_LAST  first / last stage while busy
//   oSECTOR, oSEC_HALF  sector index and half flag of the read address
//   oADDR_RD(_BIAS)     direct / mirrored read address
//   oADDR_WR(_BIAS)     direct / mirrored write address
//   oADDR_COEF          coefficient ROM address
//   oRD_VALID           read window active
//   oWE_A, oWE_B        write strobes for bank sets A / B
//   oSOURCE_DATA        bank set being read (0=A, 1=B)
// ---------------------------------------------------------------------------
module fht_control_param #(
  parameter int N_LOG2   = 10,
  parameter int A_BIT    = N_LOG2 - 2,
  parameter int PIPE_LAT = 6,
  parameter int STG_BIT  = 4
) (
  input  logic               iCLK,
  input  logic               iRESET,
`ifdef FHT_STALL_EN
  input  logic               iSTALL,
`endif
  input  logic               iSTART,
  output logic               oRDY,
  output logic               oDONE,
  output logic [STG_BIT-1:0] oSTAGE,
  output logic               oST_ZERO,
  output logic               oST_LAST,
  output logic [A_BIT-1:0]   oSECTOR,
  output logic               oSEC_HALF,
  output logic [A_BIT-1:0]   oADDR_RD,
  output logic [A_BIT-1:0]   oADDR_RD_BIAS,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic [A_BIT-1:0]   oADDR_WR_BIAS,
  output logic [A_BIT-1:0]   oADDR_COEF,
  output logic               oRD_VALID,
  output logic               oWE_A,
  output logic               oWE_B,
  output logic               oSOURCE_DATA
);

  localparam int D     = 1 << A_BIT;
  localparam int L     = 2 * D + PIPE_LAT;
  localparam int CNT_W = $clog2(L);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(L - 1);
  localparam logic [CNT_W-1:0]   RD_END     = CNT_W'(2 * D);
  localparam logic [CNT_W-1:0]   WR_START   = CNT_W'(PIPE_LAT);
  localparam logic [STG_BIT-1:0] STAGE_LAST = STG_BIT'(N_LOG2 - 1);
  localparam logic [STG_BIT-1:0] STAGE_SAT  = STG_BIT'(A_BIT);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [STG_BIT-1:0] stage;
  logic               src;
  logic               done;
  logic               stall;

`ifdef FHT_STALL_EN
  assign stall = iSTALL;
`else
  assign stall = 1'b0;
`endif

  // Offset mask within a sector of length 2^lg.
  // lg = A_BIT wraps the shifted one to zero, so the mask becomes all ones.
  function automatic logic [A_BIT-1:0] sec_mask(input int lg);
    logic [A_BIT:0] one_sh;
    one_sh = (A_BIT+1)'(1) << lg;
    return one_sh[A_BIT-1:0] - A_BIT'(1);
  endfunction

  // Mirror within the sector: base + ((sec_len - off) mod sec_len).
  // The low bits of -addr equal the low bits of -off.
  function automatic logic [A_BIT-1:0] mirror(input logic [A_BIT-1:0] addr,
                                              input logic [A_BIT-1:0] mask);
    return (addr & ~mask) | ((~addr + A_BIT'(1)) & mask);
  endfunction

  // Sequencer state.
  // Stage and bank-set toggle happen at the last count of a stage.
  // The done path is the only way the stage counter returns to 0.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state <= S_IDLE;
      cnt   <= '0;
      stage <= '0;
      src   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iSTART) begin
            state <= S_RUN;
            cnt   <= '0;
            stage <= '0;
            src   <= 1'b0;
          end
        end
        S_RUN: begin
          if (!stall) begin
            if (cnt == CNT_LAST) begin
              cnt <= '0;
              if (stage == STAGE_LAST) begin
                state <= S_IDLE;
                done  <= 1'b1;
                stage <= '0;
                src   <= 1'b0;
              end else begin
                stage <= stage + STG_BIT'(1);
                src   <= ~src;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address and strobe decode from the registered counters.
  // Sector length saturates at the bank depth, so lg = min(stage, A_BIT).
  always_comb begin
    logic             busy;
    int               lg;
    logic [A_BIT-1:0] mask;
    logic [A_BIT-1:0] rd_addr;
    logic [A_BIT-1:0] off;
    logic [CNT_W-1:0] w;

    busy    = (state == S_RUN);
    lg      = (stage > STAGE_SAT) ? A_BIT : int'(stage);
    mask    = sec_mask(lg);
    rd_addr = '0;
    w       = '0;

    oRDY          = ~busy;
    oDONE         = done;
    oSTAGE        = stage;
    oSOURCE_DATA  = src;
    oST_ZERO      = busy && (stage == '0);
    oST_LAST      = busy && (stage == STAGE_LAST);
    oRD_VALID     = 1'b0;
    oADDR_RD      = '0;
    oADDR_RD_BIAS = '0;
    oSECTOR       = '0;
    oSEC_HALF     = 1'b0;
    oADDR_COEF    = '0;
    oADDR_WR      = '0;
    oADDR_WR_BIAS = '0;
    oWE_A         = 1'b0;
    oWE_B         = 1'b0;

    if (busy && (cnt < RD_END)) begin
      rd_addr   = A_BIT'(cnt >> 1);
      oRD_VALID = 1'b1;
    end
    off           = rd_addr & mask;
    oADDR_RD      = rd_addr;
    oADDR_RD_BIAS = mirror(rd_addr, mask);
    oSECTOR       = rd_addr >> lg;
    // The top mask bit marks the second half of the sector.
    // The mask is empty for sec_len = 1.
    oSEC_HALF     = |(off & (mask ^ (mask >> 1)));
    oADDR_COEF    = off << (A_BIT - lg);

    // The second tact of each pair carries the strobe.
    // The strobe goes to the bank set that is not being read.
    if (busy && (cnt >= WR_START)) begin
      w             = cnt - WR_START;
      oADDR_WR      = A_BIT'(w >> 1);
      oADDR_WR_BIAS = mirror(A_BIT'(w >> 1), mask);
      oWE_B         = w[0] && !stall && !src;
      oWE_A         = w[0] && !stall && src;
    end
  end

endmodule

// File: tb/tb_fht_control_param.sv
// ---------------------------------------------------------------------------
// tb_fht_control_param
// Self-checking bench for fht_control_param with N_LOG2=4, PIPE_LAT=4
// (D=4, L=12).
// A small cycle model pushes the expected output word for each cycle onto
// a scoreboard queue. The word is popped and compared at the falling edge.
// The sector geometry (mirror, sector, half, coefficient) comes from a
// hand-filled table of records.
// ---------------------------------------------------------------------------
module tb_fht_control_param;

  localparam int N_LOG2   = 4;
  localparam int A_BIT    = 2;
  localparam int PIPE_LAT = 4;
  localparam int STG_BIT  = 4;
  localparam int D        = 4;
  localparam int L        = 2 * D + PIPE_LAT;
  localparam int TOTAL    = N_LOG2 * L;

  logic               iCLK = 1'b0;
  logic               iRESET;
  logic               iSTART;
  logic               iSTALL;
  logic               oRDY, oDONE, oST_ZERO, oST_LAST, oSEC_HALF;
  logic               oRD_VALID, oWE_A, oWE_B, oSOURCE_DATA;
  logic [STG_BIT-1:0] oSTAGE;
  logic [A_BIT-1:0]   oSECTOR, oADDR_RD, oADDR_RD_BIAS, oADDR_WR;
  logic [A_BIT-1:0]   oADDR_WR_BIAS, oADDR_COEF;

  typedef struct packed {
    logic               rdy;
    logic               done;
    logic [STG_BIT-1:0] stage;
    logic               st_zero;
    logic               st_last;
    logic [A_BIT-1:0]   sector;
    logic               sec_half;
    logic [A_BIT-1:0]   addr_rd;
    logic [A_BIT-1:0]   addr_rd_bias;
    logic [A_BIT-1:0]   addr_wr;
    logic [A_BIT-1:0]   addr_wr_bias;
    logic [A_BIT-1:0]   addr_coef;
    logic               rd_valid;
    logic               we_a;
    logic               we_b;
    logic               src;
  } out_t;

  // Record: inputs {lg, addr} -> expected {bias, sector, half, coef}.
  typedef struct {
    int lg;
    int addr;
    int bias;
    int sector;
    int half;
    int coef;
  } geo_t;

  geo_t geo_tab[12];
  out_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  fht_control_param #(
    .N_LOG2(N_LOG2), .A_BIT(A_BIT), .PIPE_LAT(PIPE_LAT), .STG_BIT(STG_BIT)
  ) dut (
    .iCLK(iCLK),
    .iRESET(iRESET),
`ifdef FHT_STALL_EN
    .iSTALL(iSTALL),
`endif
    .iSTART(iSTART),
    .oRDY(oRDY),
    .oDONE(oDONE),
    .oSTAGE(oSTAGE),
    .oST_ZERO(oST_ZERO),
    .oST_LAST(oST_LAST),
    .oSECTOR(oSECTOR),
    .oSEC_HALF(oSEC_HALF),
    .oADDR_RD(oADDR_RD),
    .oADDR_RD_BIAS(oADDR_RD_BIAS),
    .oADDR_WR(oADDR_WR),
    .oADDR_WR_BIAS(oADDR_WR_BIAS),
    .oADDR_COEF(oADDR_COEF),
    .oRD_VALID(oRD_VALID),
    .oWE_A(oWE_A),
    .oWE_B(oWE_B),
    .oSOURCE_DATA(oSOURCE_DATA)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic geo_t lookup(input int lg, input int addr);
    geo_t g;
    g = '{lg: -1, addr: -1, bias: 0, sector: 0, half: 0, coef: 0};
    for (int i = 0; i < 12; i++)
      if (geo_tab[i].lg == lg && geo_tab[i].addr == addr) g = geo_tab[i];
    return g;
  endfunction

  // Expected outputs while busy at position p (stage = p / L, cnt = p % L).
  function automatic out_t model(input bit busy, input int p, input bit stalled,
                                 input bit done);
    out_t e;
    int   stg, cnt, lg, w;
    geo_t g;
    e = '0;
    e.done = done;
    if (!busy) begin
      e.rdy = 1'b1;
      return e;
    end
    stg       = p / L;
    cnt       = p % L;
    lg        = (stg > A_BIT) ? A_BIT : stg;
    e.stage   = STG_BIT'(stg);
    e.st_zero = (stg == 0);
    e.st_last = (stg == N_LOG2 - 1);
    e.src     = stg[0];
    if (cnt < 2 * D) begin
      g              = lookup(lg, cnt / 2);
      e.rd_valid     = 1'b1;
      e.addr_rd      = A_BIT'(cnt / 2);
      e.addr_rd_bias = A_BIT'(g.bias);
      e.sector       = A_BIT'(g.sector);
      e.sec_half     = g.half[0];
      e.addr_coef    = A_BIT'(g.coef);
    end
    if (cnt >= PIPE_LAT) begin
      w              = cnt - PIPE_LAT;
      g              = lookup(lg, w / 2);
      e.addr_wr      = A_BIT'(w / 2);
      e.addr_wr_bias = A_BIT'(g.bias);
      if (w[0] && !stalled) begin
        if (e.src) e.we_a = 1'b1;
        else       e.we_b = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic applyStimulus(input bit busy, input int p, input bit stalled,
                               input bit done);
    sb_q.push_back(model(busy, p, stalled, done));
  endtask

  task automatic checkOutput(input bit at_edge, input string name, input int idx);
    out_t act, exp;
    if (at_edge) @(negedge iCLK);
    act = '{rdy: oRDY, done: oDONE, stage: oSTAGE, st_zero: oST_ZERO,
            st_last: oST_LAST, sector: oSECTOR, sec_half: oSEC_HALF,
            addr_rd: oADDR_RD, addr_rd_bias: oADDR_RD_BIAS, addr_wr: oADDR_WR,
            addr_wr_bias: oADDR_WR_BIAS, addr_coef: oADDR_COEF,
            rd_valid: oRD_VALID, we_a: oWE_A, we_b: oWE_B, src: oSOURCE_DATA};
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("[TB] FAIL %s[%0d]: scoreboard empty, got %h", name, idx, act);
      return;
    end
    exp = sb_q.pop_front();
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One transform from idle.
  //   abort_at >= 0: pull iRESET at that model position.
  //   stall_at >= 0: hold iSTALL for 3 cycles from that cycle index.
  // iSTART toggles randomly while busy; the DUT must ignore it.
  task automatic runTransform(input int abort_at, input int stall_at);
    int  p, i;
    bit  stl;
    iSTART = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput(1'b1, "pre_start", 0);
    @(posedge iCLK); #1;
    iSTART = 1'b0;
    p = 0;
    i = 0;
    while (p < TOTAL && i < TOTAL + 10) begin
      stl    = (stall_at >= 0) && (i >= stall_at) && (i < stall_at + 3);
      iSTALL = stl;
`ifndef FHT_STALL_EN
      stl = 1'b0;
`endif
      applyStimulus(1'b1, p, stl, 1'b0);
      checkOutput(1'b1, "run", p);
      if (p == abort_at) begin
        iRESET = 1'b0;
        iSTART = 1'b0;
        iSTALL = 1'b0;
        #1;
        applyStimulus(1'b0, 0, 1'b0, 1'b0);
        checkOutput(1'b0, "abort", p);
        @(posedge iCLK); #1;
        iRESET = 1'b1;
        return;
      end
      @(posedge iCLK); #1;
      if (!stl) p++;
      i++;
      iSTART = (p < TOTAL) ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    iSTALL = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    checkOutput(1'b1, "done_cycle", i);
    @(posedge iCLK); #1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput(1'b1, "after_done", i + 1);
    @(posedge iCLK); #1;
  endtask

  initial begin
    // lg 0: sec_len 1 -> identity mirror, sector = addr
    geo_tab[0]  = '{0, 0, 0, 0, 0, 0};
    geo_tab[1]  = '{0, 1, 1, 1, 0, 0};
    geo_tab[2]  = '{0, 2, 2, 2, 0, 0};
    geo_tab[3]  = '{0, 3, 3, 3, 0, 0};
    // lg 1: sec_len 2 -> mirror is identity, coef 0,2
    geo_tab[4]  = '{1, 0, 0, 0, 0, 0};
    geo_tab[5]  = '{1, 1, 1, 0, 1, 2};
    geo_tab[6]  = '{1, 2, 2, 1, 0, 0};
    geo_tab[7]  = '{1, 3, 3, 1, 1, 2};
    // lg 2: sec_len 4 -> mirror 0,3,2,1, coef = off
    geo_tab[8]  = '{2, 0, 0, 0, 0, 0};
    geo_tab[9]  = '{2, 1, 3, 0, 0, 1};
    geo_tab[10] = '{2, 2, 2, 0, 1, 2};
    geo_tab[11] = '{2, 3, 1, 0, 1, 3};

    iRESET = 1'b0;
    iSTART = 1'b0;
    iSTALL = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput(1'b1, "reset_state", 0);
    @(posedge iCLK); #1;
    iRESET = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput(1'b1, "idle", 0);
    @(posedge iCLK); #1;

    $display("[TB] full transform");
    runTransform(-1, -1);
    $display("[TB] reset abort at stage 2 cnt 7");
    runTransform(2 * L + 7, -1);
    $display("[TB] restart after abort");
    runTransform(-1, -1);
`ifdef FHT_STALL_EN
    $display("[TB] 3-cycle stall in stage 1");
    runTransform(-1, L + 5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
